// File: rtl/button_pulse_gen.sv
// button_pulse_gen: conditions the raw write / select-up / select-down
// push-buttons into clean single-tick pulses aligned to i_ena.
// Each button is synchronised, debounced on i_ena ticks and edge-detected.
// The select buttons also auto-repeat while held, and a select pulse is
// suppressed while the opposite select button is debounced-pressed.
module button_pulse_gen #(
  parameter int unsigned DEBOUNCE_TICKS = 4,
  parameter int unsigned REPEAT_DELAY   = 50,
  parameter int unsigned REPEAT_PERIOD  = 10,
  parameter int unsigned CNT_W          = 8,
  parameter bit          ACTIVE_LOW     = 1'b1
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_ena,
  input  logic i_btn_wr,
  input  logic i_btn_inc,
  input  logic i_btn_dec,
  output logic o_wr_pulse,
  output logic o_sel_inc_pulse,
  output logic o_sel_dec_pulse
);

  localparam int unsigned NB      = 3;
  localparam int unsigned IDX_WR  = 0;
  localparam int unsigned IDX_INC = 1;
  localparam int unsigned IDX_DEC = 2;

  // Pin level that means "released"; synchronisers reset to it.
  localparam logic REL_LEVEL = ACTIVE_LOW ? 1'b1 : 1'b0;

  localparam logic [CNT_W-1:0] DC_LAST   = CNT_W'(DEBOUNCE_TICKS - 1);
  localparam logic [CNT_W-1:0] HC_LAST   = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] HC_RELOAD = CNT_W'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [NB-1:0] pin_raw;
  logic [NB-1:0] db_now;   // debounced level after this tick's update
  logic [NB-1:0] rise_v;   // accept tick with db going 0->1

  logic [IDX_DEC:IDX_INC] rep_v;  // auto-repeat events, select buttons only

  logic fire_wr;
  logic fire_inc;
  logic fire_dec;

  logic wr_pulse_q,  wr_pulse_d;
  logic inc_pulse_q, inc_pulse_d;
  logic dec_pulse_q, dec_pulse_d;

  assign pin_raw = {i_btn_dec, i_btn_inc, i_btn_wr};

  genvar g;

  // Per-button synchroniser and debouncer.
  generate
    for (g = 0; g < NB; g++) begin : gen_btn
      logic             sync1_q, sync1_d;
      logic             sync2_q, sync2_d;
      logic             pressed;
      logic             db_q, db_d;
      logic [CNT_W-1:0] dc_q, dc_d;
      logic             accept;

      // Two-flop synchroniser chain for the asynchronous pin.
      always_comb begin
        sync1_d = pin_raw[g];
        sync2_d = sync1_q;
      end

      // Synchroniser flops reset to the released level.
      always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
          sync1_q <= REL_LEVEL;
          sync2_q <= REL_LEVEL;
        end else begin
          sync1_q <= sync1_d;
          sync2_q <= sync2_d;
        end
      end

      // Normalise polarity so 1 always means pressed.
      always_comb begin
        pressed = sync2_q ^ REL_LEVEL;
      end

      // Accept a new level only after DEBOUNCE_TICKS consecutive ticks.
      always_comb begin
        db_d   = db_q;
        dc_d   = dc_q;
        accept = 1'b0;
        if (i_ena) begin
          if (pressed == db_q) begin
            dc_d = '0;
          end else if (dc_q == DC_LAST) begin
            db_d   = pressed;
            dc_d   = '0;
            accept = 1'b1;
          end else begin
            dc_d = dc_q + CNT_W'(1);
          end
        end
      end

      // Debounce state and counter.
      always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
          db_q <= 1'b0;
          dc_q <= '0;
        end else begin
          db_q <= db_d;
          dc_q <= dc_d;
        end
      end

      assign db_now[g] = db_d;
      assign rise_v[g] = accept & db_d;
    end
  endgenerate

  // Per-select-button auto-repeat counter.
  generate
    for (g = IDX_INC; g <= IDX_DEC; g++) begin : gen_rep
      logic [CNT_W-1:0] hc_q, hc_d;
      logic             rep;

      // Count held ticks; first repeat after REPEAT_DELAY, then every
      // REPEAT_PERIOD by reloading the counter part-way up.
      always_comb begin
        hc_d = hc_q;
        rep  = 1'b0;
        if (i_ena) begin
          if (rise_v[g]) begin
            hc_d = '0;
          end else if (db_now[g]) begin
            if (hc_q == HC_LAST) begin
              rep  = 1'b1;
              hc_d = HC_RELOAD;
            end else begin
              hc_d = hc_q + CNT_W'(1);
            end
          end else begin
            hc_d = '0;
          end
        end
      end

      // Repeat counter register.
      always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
          hc_q <= '0;
        end else begin
          hc_q <= hc_d;
        end
      end

      assign rep_v[g] = rep;
    end
  endgenerate

  // Fire terms: select pulses are blocked while the opposite button is held.
  always_comb begin
    fire_wr  = rise_v[IDX_WR];
    fire_inc = (rise_v[IDX_INC] | rep_v[IDX_INC]) & ~db_now[IDX_DEC];
    fire_dec = (rise_v[IDX_DEC] | rep_v[IDX_DEC]) & ~db_now[IDX_INC];
  end

  // Outputs load only on i_ena so each pulse lasts one full tick period.
  always_comb begin
    wr_pulse_d  = wr_pulse_q;
    inc_pulse_d = inc_pulse_q;
    dec_pulse_d = dec_pulse_q;
    if (i_ena) begin
      wr_pulse_d  = fire_wr;
      inc_pulse_d = fire_inc;
      dec_pulse_d = fire_dec;
    end
  end

  // Output registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_pulse_q  <= 1'b0;
      inc_pulse_q <= 1'b0;
      dec_pulse_q <= 1'b0;
    end else begin
      wr_pulse_q  <= wr_pulse_d;
      inc_pulse_q <= inc_pulse_d;
      dec_pulse_q <= dec_pulse_d;
    end
  end

  assign o_wr_pulse      = wr_pulse_q;
  assign o_sel_inc_pulse = inc_pulse_q;
  assign o_sel_dec_pulse = dec_pulse_q;

endmodule

// File: tb/tb_button_pulse_gen.sv
// Directed bench for button_pulse_gen with default parameters, active-low
// buttons and i_ena every 5 clocks.
module tb_button_pulse_gen;

  logic clk     = 1'b0;
  logic rst     = 1'b0;
  logic ena     = 1'b0;
  logic btn_wr  = 1'b1;
  logic btn_inc = 1'b1;
  logic btn_dec = 1'b1;
  logic o_wr;
  logic o_inc;
  logic o_dec;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  int wr_rises = 0, inc_rises = 0, dec_rises = 0;
  int wr_hi    = 0, inc_hi    = 0, dec_hi    = 0;
  logic wr_prev = 1'b0, inc_prev = 1'b0, dec_prev = 1'b0;

  int s_wr_r, s_inc_r, s_dec_r, s_wr_h, s_inc_h, s_dec_h;

  button_pulse_gen #(
    .DEBOUNCE_TICKS(4),
    .REPEAT_DELAY  (50),
    .REPEAT_PERIOD (10),
    .CNT_W         (8),
    .ACTIVE_LOW    (1'b1)
  ) dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_ena          (ena),
    .i_btn_wr       (btn_wr),
    .i_btn_inc      (btn_inc),
    .i_btn_dec      (btn_dec),
    .o_wr_pulse     (o_wr),
    .o_sel_inc_pulse(o_inc),
    .o_sel_dec_pulse(o_dec)
  );

  always #5 clk = ~clk;

  // Pulse counts and high-clock counts, sampled mid-cycle.
  always @(negedge clk) begin
    if (o_wr  && !wr_prev)  wr_rises++;
    if (o_inc && !inc_prev) inc_rises++;
    if (o_dec && !dec_prev) dec_rises++;
    if (o_wr)  wr_hi++;
    if (o_inc) inc_hi++;
    if (o_dec) dec_hi++;
    wr_prev  = o_wr;
    inc_prev = o_inc;
    dec_prev = o_dec;
  end

  // One i_ena period: four idle clocks then one clock with i_ena high.
  task automatic tick();
    repeat (4) @(negedge clk);
    ena = 1'b1;
    @(negedge clk);
    ena = 1'b0;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b (failure %0d)", tag, obs, exp, n_fail);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d (failure %0d)", tag, obs, exp, n_fail);
    end
  endtask

  task automatic outs(input string tag, input logic e_wr, input logic e_inc, input logic e_dec);
    chk1({tag, " wr"},  o_wr,  e_wr);
    chk1({tag, " inc"}, o_inc, e_inc);
    chk1({tag, " dec"}, o_dec, e_dec);
  endtask

  task automatic snap();
    s_wr_r = wr_rises; s_inc_r = inc_rises; s_dec_r = dec_rises;
    s_wr_h = wr_hi;    s_inc_h = inc_hi;    s_dec_h = dec_hi;
  endtask

  task automatic deltas(input string tag, input int e_wr_r, input int e_inc_r, input int e_dec_r,
                        input int e_wr_h, input int e_inc_h, input int e_dec_h);
    chkn({tag, " wr pulses"},  wr_rises  - s_wr_r,  e_wr_r);
    chkn({tag, " inc pulses"}, inc_rises - s_inc_r, e_inc_r);
    chkn({tag, " dec pulses"}, dec_rises - s_dec_r, e_dec_r);
    chkn({tag, " wr clocks"},  wr_hi     - s_wr_h,  e_wr_h);
    chkn({tag, " inc clocks"}, inc_hi    - s_inc_h, e_inc_h);
    chkn({tag, " dec clocks"}, dec_hi    - s_dec_h, e_dec_h);
  endtask

  initial begin
    // Reset with buttons idle
    #2 rst = 1'b1;
    #1 outs("reset", 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    snap();
    for (int i = 0; i < 100; i++) tick();
    outs("idle100", 1'b0, 1'b0, 1'b0);
    deltas("idle100", 0, 0, 0, 0, 0, 0);

    // Bouncy write press
    snap();
    btn_wr = 1'b0;
    tick(); chk1("s2 bounce t1", o_wr, 1'b0);
    tick(); chk1("s2 bounce t2", o_wr, 1'b0);
    btn_wr = 1'b1;
    tick(); chk1("s2 bounce high", o_wr, 1'b0);
    btn_wr = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick(); chk1($sformatf("s2 low t%0d", i), o_wr, 1'b0);
    end
    tick(); outs("s2 accept", 1'b1, 1'b0, 1'b0);
    tick(); chk1("s2 after pulse", o_wr, 1'b0);
    for (int i = 0; i < 200; i++) tick();
    chk1("s2 held", o_wr, 1'b0);
    deltas("s2", 1, 0, 0, 5, 0, 0);

    // Reset while write held, then reset mid-pulse
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick(); chk1($sformatf("s6 t%0d", i), o_wr, 1'b0);
    end
    tick(); chk1("s6 t4 pulse", o_wr, 1'b1);
    #2 rst = 1'b1;
    #1 outs("s1 reset mid-pulse", 1'b0, 1'b0, 1'b0);
    btn_wr = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    snap();
    for (int i = 0; i < 100; i++) tick();
    deltas("s1 idle after reset", 0, 0, 0, 0, 0, 0);

    // Auto-repeat on inc: release after k=76, accepted at k=80
    snap();
    btn_inc = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick(); chk1($sformatf("s3 pre t%0d", i), o_inc, 1'b0);
    end
    tick(); outs("s3 k=0", 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 85; k++) begin
      tick();
      chk1($sformatf("s3 inc k=%0d", k), o_inc, (k == 50 || k == 60 || k == 70));
      if (k == 76) btn_inc = 1'b1;
    end
    deltas("s3", 0, 4, 0, 0, 20, 0);

    // Conflict: dec accepted at k=10, inc released and accepted at k=76
    snap();
    btn_inc = 1'b0;
    for (int i = 1; i <= 3; i++) tick();
    tick(); outs("s4 k=0", 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 100; k++) begin
      tick();
      chk1($sformatf("s4 inc k=%0d", k), o_inc, 1'b0);
      chk1($sformatf("s4 dec k=%0d", k), o_dec, (k == 80 || k == 90));
      if (k == 6)  btn_dec = 1'b0;
      if (k == 72) btn_inc = 1'b1;
      if (k == 92) btn_dec = 1'b1;
    end
    for (int i = 0; i < 5; i++) tick();
    deltas("s4", 0, 1, 2, 0, 5, 10);

    // Three-tick glitch on dec is rejected
    snap();
    btn_dec = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    btn_dec = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(); chk1($sformatf("s5 glitch t%0d", i), o_dec, 1'b0);
    end
    deltas("s5", 0, 0, 0, 0, 0, 0);

    // Simultaneous write and inc press both pulse
    btn_wr  = 1'b0;
    btn_inc = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick(); outs($sformatf("s7 t%0d", i), 1'b0, 1'b0, 1'b0);
    end
    tick(); outs("s7 accept", 1'b1, 1'b1, 1'b0);
    btn_wr  = 1'b1;
    btn_inc = 1'b1;
    tick(); outs("s7 after", 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/button_pulse_gen.md
# button_pulse_gen

Front-end conditioner that turns the three raw clock-setting push-buttons (write, select-up, select-down) into clean, enable-aligned pulses for `input_control`. It sits between the board pins and `input_control`. Per button it synchronises, debounces on `i_ena` ticks and edge-detects. The select buttons also auto-repeat while held. Each output pulse is held for exactly one `i_ena` period, so `input_control` samples it exactly once.

## Interface
- `DEBOUNCE_TICKS`, 4: consecutive `i_ena` ticks a new level must persist before it is accepted (≥1).
- `REPEAT_DELAY`, 50: `i_ena` ticks from the press pulse to the first auto-repeat pulse.
- `REPEAT_PERIOD`, 10: `i_ena` ticks between subsequent repeat pulses (1 ≤ `REPEAT_PERIOD` ≤ `REPEAT_DELAY`).
- `CNT_W`, 8: width of the debounce and repeat counters; must hold `REPEAT_DELAY`-1.
- `ACTIVE_LOW`, 1: 1 means raw pins read 0 when pressed.

Ports:
- `i_clk` in 1: system clock.
- `i_reset` in 1: reset, asynchronous and active-high.
- `i_ena` in 1: single-cycle sample tick, the same strobe that drives `input_control`.
- `i_btn_wr` in 1: raw write button, asynchronous to `i_clk`.
- `i_btn_inc` in 1: raw select-up button, asynchronous.
- `i_btn_dec` in 1: raw select-down button, asynchronous.
- `o_wr_pulse` out 1: write request, goes to `input_control` `i_wr_pulse`.
- `o_sel_inc_pulse` out 1: select up, goes to `i_sel_inc_pulse`.
- `o_sel_dec_pulse` out 1: select down, goes to `i_sel_dec_pulse`.

## Operation
- **Synchroniser.** Each raw pin passes through 2 flops clocked every `i_clk`. The synchronised level is then inverted if `ACTIVE_LOW`, giving `p` (1 = pressed). On reset the flops load the released value.
- **Debounce.** Per button there is a state `db` (reset 0) and a counter `dc` (reset 0). Both update only on cycles where `i_ena`=1:
  - `p`==`db`: `dc`<=0.
  - `p`!=`db` and `dc`==`DEBOUNCE_TICKS`-1: `db`<=`p`, `dc`<=0. This is the accept tick.
  - otherwise: `dc`<=`dc`+1.
  - A glitch shorter than `DEBOUNCE_TICKS` ticks is discarded.
- **Rise event.** An accept tick on which `db` goes 0→1.
- **Repeat counter.** `o_sel_inc_pulse` and `o_sel_dec_pulse` each have a counter `hc` (reset 0), updated on `i_ena` ticks:
  - Rise tick: `hc`<=0.
  - `db`=1 after the tick, no rise: if `hc`==`REPEAT_DELAY`-1, raise a repeat event and set `hc`<=`REPEAT_DELAY`-`REPEAT_PERIOD`; else `hc`<=`hc`+1.
  - `db`=0: `hc`<=0.
- **Fire conditions.** Evaluated on each `i_ena` tick:
  - `fire_wr` = write rise. Write never repeats.
  - `fire_inc` = (inc rise | inc repeat) & ~`db_dec`, using `db_dec` after this tick's update.
  - `fire_dec` = (dec rise | dec repeat) & ~`db_inc`, using `db_inc` after this tick's update.
  - inc and dec both debounced-pressed: neither fires. Their repeat counters keep running.
  - Write is independent of the select buttons. Simultaneous write and select pulses are allowed.
- **Outputs.** On an `i_ena` tick, each output <= its fire term. Otherwise outputs hold their value.
- **Reset.** Reset at any time asynchronously clears all outputs, `db`, `dc`, `hc` and the synchronisers.
  - A button held through reset is seen as a new press: a pulse follows `DEBOUNCE_TICKS` ticks after release of reset, plus synchroniser delay.

## Timing
- All outputs are 0 in reset.
- Outputs change only on the rising edge of a cycle with `i_ena`=1, and each pulse is high for exactly one `i_ena` period.
- Consecutive pulses on the same output are separated by at least one `i_ena` period low. The only exception is `REPEAT_PERIOD`=1, where the output stays high continuously.
- Press latency: 2 `i_clk` of synchronisation, then the output rises on the `DEBOUNCE_TICKS`-th consecutive `i_ena` tick that sees the pressed level.
- First repeat: `REPEAT_DELAY` ticks after the press pulse tick. Later repeats: every `REPEAT_PERIOD` ticks.
- Release: no pulse is produced. Repeats stop on the accept tick of the release.
- Counters never wrap: `dc` saturates at `DEBOUNCE_TICKS`-1 and `hc` at `REPEAT_DELAY`-1 by construction.

## Test plan
All scenarios use the defaults, `ACTIVE_LOW`=1, and `i_ena` every 5 clocks.
1. **Reset.** Assert `i_reset` mid-pulse -> all outputs 0 immediately; after release, `o_*` stay 0 with buttons idle (high) for 100 ticks.
2. **Clean and bouncy write press.** Drive `i_btn_wr` low for 2 ticks, high for 1, then low continuously -> exactly one `o_wr_pulse`, 5 clocks wide, on the 4th consecutive low tick. Holding 200 ticks gives no further pulse.
3. **Auto-repeat.** Hold `i_btn_inc` low for 80 ticks -> pulses at ticks 0, 50, 60 and 70 relative to the first, i.e. 4 pulses. Release gives no pulse and `hc` returns to 0.
4. **Conflict.** Press inc; 10 ticks later also press dec (debounced) -> the inc pulse appears at the start, then no `o_sel_inc_pulse` or `o_sel_dec_pulse` while both are held. Releasing inc -> no new dec press pulse; dec repeats resume per `hc` once the `db_inc`=0 accept tick has passed.
5. **Glitch rejection.** A 3-tick low glitch on `i_btn_dec` -> no pulse.
6. **Reset with button held.** Hold `i_btn_wr` low, then pulse `i_reset` -> exactly one `o_wr_pulse` on the 4th `i_ena` tick after synchronisation.
